// File: rtl/nic8_isa_pkg.sv
// NIC8 ISA definitions shared by the instruction sequencer and its helpers:
// sequencer state encoding, opcode field positions and jump condition codes.
package nic8_isa_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_OPERAND = 2'd2,
    ST_HALT    = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_ZERO   = 2'b01,
    COND_CARRY  = 2'b10,
    COND_NEVER  = 2'b11
  } jump_cond_e;

  localparam int unsigned OP_JUMP_BIT = 7;
  localparam int unsigned OP_IMM_BIT  = 6;
  localparam int unsigned OP_COND_HI  = 6;
  localparam int unsigned OP_COND_LO  = 5;

  localparam logic [7:0] HALT_OP_DEFAULT = 8'hFF;

  function automatic logic is_jump(input logic [7:0] op);
    return op[OP_JUMP_BIT];
  endfunction

  // Jumps carry their target in the following byte, so they are two-byte too.
  function automatic logic is_two_byte(input logic [7:0] op);
    return op[OP_JUMP_BIT] | op[OP_IMM_BIT];
  endfunction

endpackage

// File: rtl/jump_condition.sv
// Evaluates a jump condition code against the current ALU flags.
module jump_condition
  import nic8_isa_pkg::*;
(
  input  logic [1:0] cond,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (jump_cond_e'(cond))
      COND_ALWAYS: taken = 1'b1;
      COND_ZERO:   taken = zero_flag;
      COND_CARRY:  taken = carry_flag;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// NIC8 instruction sequencer: registered state and IR, combinational strobe
// decode into the program counter, ROM and datapath.
module instruction_sequencer
  import nic8_isa_pkg::*;
#(
  parameter logic [7:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic [7:0] rom_data,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output logic       pc_inc,
  output logic       pc_jump,
  output logic       rom_oe,
  output logic       ir_load,
  output logic       exec,
  output logic [7:0] ir,
  output logic [1:0] state,
  output logic       halted
);

  seq_state_e state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       jump_taken;

  jump_condition u_jump_condition (
    .cond       (ir_q[OP_COND_HI:OP_COND_LO]),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .taken      (jump_taken)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_inc  = 1'b0;
    pc_jump = 1'b0;
    rom_oe  = 1'b0;
    ir_load = 1'b0;
    exec    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (run | step) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          ir_d    = rom_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (ir_q == HALT_OP) begin
          state_d = ST_HALT;
        end else if (is_two_byte(ir_q)) begin
          state_d = ST_OPERAND;
        end else begin
          exec    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_OPERAND: begin
        rom_oe = 1'b1;
        if (is_jump(ir_q)) begin
          pc_jump = jump_taken;
          pc_inc  = ~jump_taken;
        end else begin
          pc_inc = 1'b1;
          exec   = 1'b1;
        end
        state_d = ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase

    // Reset wins over every state and also masks the strobes of that cycle.
    if (reset) begin
      state_d = ST_FETCH;
      ir_d    = '0;
      pc_inc  = 1'b0;
      pc_jump = 1'b0;
      rom_oe  = 1'b0;
      ir_load = 1'b0;
      exec    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ir_q    <= ir_d;
  end

  assign ir     = ir_q;
  assign state  = state_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed table, multi-cycle
// corner sequences and a randomized run against an instruction-level model.
module tb_instruction_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, step, zero_flag, carry_flag;
  logic [7:0] rom_data;
  logic       pc_inc, pc_jump, rom_oe, ir_load, exec, halted;
  logic [7:0] ir;
  logic [1:0] state;

  logic [7:0] rom [256];
  logic [7:0] pc;

  int checks   = 0;
  int failures = 0;

  instruction_sequencer #(.HALT_OP(8'hFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .rom_data   (rom_data),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .pc_inc     (pc_inc),
    .pc_jump    (pc_jump),
    .rom_oe     (rom_oe),
    .ir_load    (ir_load),
    .exec       (exec),
    .ir         (ir),
    .state      (state),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Program memory and program counter driven by the sequencer's strobes.
  assign rom_data = rom[pc];
  always @(posedge clk) begin
    if (reset)        pc <= 8'h00;
    else if (pc_jump) pc <= rom_data;
    else if (pc_inc)  pc <= pc + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < 256; i++) rom[i] = 8'h01;
    rom[0] = b0;
    rom[1] = b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Runs from FETCH until the sequencer is back in FETCH, counting strobes.
  task automatic run_instr(output int cycles, output int n_exec, output int n_jump,
                           output int n_inc, output int n_both);
    cycles = 0; n_exec = 0; n_jump = 0; n_inc = 0; n_both = 0;
    do begin
      @(negedge clk);
      n_exec += int'(exec);
      n_jump += int'(pc_jump);
      n_inc  += int'(pc_inc);
      n_both += int'(pc_inc & pc_jump);
      tick();
      cycles++;
    end while (state != 2'd0 && cycles < 8);
  endtask

  typedef struct {
    logic [7:0] op;
    logic [7:0] opnd;
    logic       zf;
    logic       cf;
    int         cycles;
    int         execs;
    int         jumps;
    int         incs;
    logic [7:0] pc_after;
  } vec_t;

  // Behavioural reference: instruction length and position within it.
  function automatic logic cond_taken(input logic [7:0] op, input logic z, input logic c);
    case (op[6:5])
      2'b00:   return 1'b1;
      2'b01:   return z;
      2'b10:   return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int instr_len(input logic [7:0] op);
    return (op[7] || op[6]) ? 2 : 1;
  endfunction

  initial begin
    vec_t vecs [10];
    int cyc, nex, njp, ninc, nboth;
    logic [3:0] inc_bits, exec_bits, jump_bits;
    int strobe_cnt, load_cnt;
    logic       m_halt;
    logic [7:0] m_ir, m_pc, cur;
    int         m_pos;
    logic       e_inc, e_jmp, e_oe, e_ld, e_exec;
    logic [1:0] e_state;

    reset = 1'b1; run = 1'b0; step = 1'b0; zero_flag = 1'b0; carry_flag = 1'b0;
    load_prog(8'h00, 8'h00);

    vecs[0] = '{8'h01, 8'h00, 1'b0, 1'b0, 2, 1, 0, 1, 8'h01};
    vecs[1] = '{8'h3F, 8'h00, 1'b1, 1'b1, 2, 1, 0, 1, 8'h01};
    vecs[2] = '{8'h41, 8'h55, 1'b0, 1'b0, 3, 1, 0, 2, 8'h02};
    vecs[3] = '{8'h80, 8'h10, 1'b0, 1'b0, 3, 0, 1, 1, 8'h10};
    vecs[4] = '{8'hA0, 8'h10, 1'b0, 1'b1, 3, 0, 0, 2, 8'h02};
    vecs[5] = '{8'hA0, 8'h10, 1'b1, 1'b0, 3, 0, 1, 1, 8'h10};
    vecs[6] = '{8'hC0, 8'h10, 1'b0, 1'b1, 3, 0, 1, 1, 8'h10};
    vecs[7] = '{8'hC0, 8'h10, 1'b1, 1'b0, 3, 0, 0, 2, 8'h02};
    vecs[8] = '{8'hE0, 8'h10, 1'b1, 1'b1, 3, 0, 0, 2, 8'h02};
    vecs[9] = '{8'h9F, 8'h20, 1'b0, 1'b0, 3, 0, 1, 1, 8'h20};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_state", state, 2'd0);
    check("reset_ir", ir, 8'h00);
    check("reset_halted", halted, 1'b0);
    check("reset_idle_strobes", {pc_inc, pc_jump, rom_oe, ir_load, exec}, 5'b0);

    // Single-instruction table
    for (int i = 0; i < 10; i++) begin
      load_prog(vecs[i].op, vecs[i].opnd);
      do_reset();
      zero_flag  = vecs[i].zf;
      carry_flag = vecs[i].cf;
      run = 1'b1;
      run_instr(cyc, nex, njp, ninc, nboth);
      run = 1'b0;
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cycles);
      check($sformatf("vec%0d_exec", i), nex, vecs[i].execs);
      check($sformatf("vec%0d_jump", i), njp, vecs[i].jumps);
      check($sformatf("vec%0d_inc", i), ninc, vecs[i].incs);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].pc_after);
      check($sformatf("vec%0d_ir", i), ir, vecs[i].op);
      check($sformatf("vec%0d_inc_jump_overlap", i), nboth, 0);
    end
    zero_flag = 1'b0; carry_flag = 1'b0;

    // Two one-byte instructions back to back
    load_prog(8'h01, 8'h02);
    do_reset();
    run = 1'b1;
    inc_bits = '0; exec_bits = '0; jump_bits = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      inc_bits[c] = pc_inc; exec_bits[c] = exec; jump_bits[c] = pc_jump;
      tick();
    end
    check("seq_1byte_inc", inc_bits, 4'b0101);
    check("seq_1byte_exec", exec_bits, 4'b1010);
    check("seq_1byte_jump", jump_bits, 4'b0000);

    // Immediate instruction operand cycle
    load_prog(8'h41, 8'h55);
    do_reset();
    run = 1'b1;
    tick(); tick();
    run = 1'b0;
    @(negedge clk);
    check("imm_operand_strobes", {rom_oe, exec, pc_inc, pc_jump}, 4'b1110);
    check("imm_operand_ir", ir, 8'h41);
    tick();

    // HALT is sticky until reset
    load_prog(8'hFF, 8'h00);
    do_reset();
    run = 1'b1;
    tick(); tick();
    check("halt_halted", halted, 1'b1);
    check("halt_state", state, 2'd3);
    strobe_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step = c[0];
      zero_flag = c[1];
      @(negedge clk);
      strobe_cnt += int'(pc_inc | pc_jump | rom_oe | ir_load | exec);
      tick();
    end
    check("halt_no_strobes", strobe_cnt, 0);
    check("halt_sticky", halted, 1'b1);
    do_reset();
    check("halt_reset_state", state, 2'd0);
    check("halt_reset_halted", halted, 1'b0);
    zero_flag = 1'b0;

    // Single step pulse
    load_prog(8'h01, 8'h01);
    do_reset();
    step = 1'b1;
    load_cnt = 0; nex = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      load_cnt += int'(ir_load); nex += int'(exec);
      tick();
      step = 1'b0;
    end
    check("step_pulse_loads", load_cnt, 1);
    check("step_pulse_execs", nex, 1);
    check("step_pulse_state", state, 2'd0);
    check("step_pulse_pc", pc, 8'h01);

    // Step held high: one instruction per FETCH visit
    do_reset();
    step = 1'b1;
    load_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) step = 1'b0;
      @(negedge clk);
      load_cnt += int'(ir_load);
      tick();
    end
    check("step_level_loads", load_cnt, 3);
    check("step_level_pc", pc, 8'h03);

    // run dropped mid-instruction still completes it
    load_prog(8'h41, 8'h55);
    do_reset();
    run = 1'b1;
    nex = 0; ninc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nex += int'(exec); ninc += int'(pc_inc);
      tick();
      run = 1'b0;
    end
    check("run_drop_exec", nex, 1);
    check("run_drop_pc", pc, 8'h02);
    check("run_drop_state", state, 2'd0);

    // Reset during OPERAND of a taken jump
    load_prog(8'h80, 8'h10);
    do_reset();
    run = 1'b1;
    tick(); tick();
    check("rst_operand_in_operand", state, 2'd2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_operand_strobes", {pc_inc, pc_jump, rom_oe, ir_load, exec}, 5'b0);
    tick();
    reset = 1'b0; run = 1'b0;
    check("rst_operand_state", state, 2'd0);
    check("rst_operand_ir", ir, 8'h00);
    check("rst_operand_pc", pc, 8'h00);

    // Randomized program against the instruction-level model
    for (int i = 0; i < 256; i++) begin
      cur = 8'($urandom);
      if (cur == 8'hFF) cur = 8'h00;
      if ($urandom_range(0, 79) == 0) cur = 8'hFF;
      rom[i] = cur;
    end
    do_reset();
    m_halt = 1'b0; m_ir = 8'h00; m_pc = 8'h00; m_pos = 0;
    for (int c = 0; c < 1500; c++) begin
      reset      = ($urandom_range(0, 99) < 2);
      run        = ($urandom_range(0, 9) < 6);
      step       = ($urandom_range(0, 2) == 0);
      zero_flag  = 1'($urandom);
      carry_flag = 1'($urandom);
      @(negedge clk);
      cur = rom[m_pc];
      e_inc = 0; e_jmp = 0; e_oe = 0; e_ld = 0; e_exec = 0;
      if (!reset && !m_halt) begin
        if (m_pos == 0) begin
          if (run || step) begin e_ld = 1; e_inc = 1; end
        end else if (m_pos == 1) begin
          if (m_ir != 8'hFF && instr_len(m_ir) == 1) e_exec = 1;
        end else begin
          e_oe = 1;
          if (m_ir[7]) begin
            if (cond_taken(m_ir, zero_flag, carry_flag)) e_jmp = 1;
            else e_inc = 1;
          end else begin
            e_inc = 1; e_exec = 1;
          end
        end
      end
      e_state = m_halt ? 2'd3 : m_pos[1:0];
      check("rand_outputs", {pc_inc, pc_jump, rom_oe, ir_load, exec, halted, state, ir},
            {e_inc, e_jmp, e_oe, e_ld, e_exec, m_halt, e_state, m_ir});
      check("rand_pc", pc, m_pc);
      if (reset) begin
        m_halt = 0; m_pos = 0; m_ir = 8'h00; m_pc = 8'h00;
      end else if (!m_halt) begin
        if (e_jmp) m_pc = cur;
        else if (e_inc) m_pc = m_pc + 8'd1;
        if (m_pos == 0) begin
          if (run || step) begin m_ir = cur; m_pos = 1; end
        end else if (m_pos == 1) begin
          if (m_ir == 8'hFF) m_halt = 1;
          else m_pos = (instr_len(m_ir) == 2) ? 2 : 0;
        end else begin
          m_pos = 0;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter: HALT_OP, 8'hFF, opcode that stops the sequencer.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 run  input  1  free-run enable; low holds the sequencer in FETCH.
REQ-005 step  input  1  while run=0, a one-cycle pulse releases exactly one instruction.
REQ-006 rom_data  input  8  program memory byte at current pc.
REQ-007 zero_flag, carry_flag  input  1 each  ALU flags, sampled in OPERAND.
REQ-008 pc_inc  output  1  drives program-counter increment (immediate) input.
REQ-009 pc_jump  output  1  drives program-counter load (doJump) input.
REQ-010 rom_oe  output  1  rom_data onto dbus (operand or jump target).
REQ-011 ir_load  output  1  opcode capture strobe (mirrors internal IR write).
REQ-012 exec  output  1  one-cycle execute strobe for datapath.
REQ-013 ir  output  8  current instruction register.
REQ-014 state  output  2  FETCH=0, DECODE=1, OPERAND=2, HALT=3.
REQ-015 halted  output  1  high in HALT.

Function
REQ-016 Opcode fields: op[7]=1 jump (2-byte, target follows); op[6]=1 with op[7]=0 two-byte immediate-operand instruction; otherwise one-byte; op[6:5] for jumps: 00 always, 01 if zero, 10 if carry, 11 never.
REQ-017 FETCH, when (run | step): ir_load=1, pc_inc=1, IR<=rom_data, next DECODE; otherwise all strobes 0, stay FETCH.
REQ-018 DECODE: IR==HALT_OP -> HALT, no strobes; 2-byte -> OPERAND, no strobes; 1-byte -> exec=1, next FETCH.
REQ-019 OPERAND: rom_oe=1; jump taken -> pc_jump=1, pc_inc=0; jump not taken -> pc_inc=1; non-jump 2-byte -> pc_inc=1, exec=1; next FETCH.
REQ-020 pc_inc and pc_jump SHALL never be high in the same cycle.
REQ-021 exec SHALL never assert on a jump instruction.
REQ-022 Timing: 1-byte = 2 cycles, 2-byte = 3 cycles, measured FETCH to next FETCH.
REQ-023 Flags sampled combinationally in the OPERAND cycle only; flag changes elsewhere ignored.
REQ-024 HALT is sticky: all strobes 0, run/step ignored, exit only by reset.
REQ-025 step high for multiple cycles with run=0 SHALL release one instruction per FETCH visit (level-sensitive in FETCH only).
REQ-026 Outputs are combinational from state, IR, flags and run/step; no extra latency.
REQ-027 Deassertion of run mid-instruction SHALL NOT abort it; gating applies only in FETCH.

Reset
REQ-028 reset high on a clock edge: state<=FETCH, IR<=8'h00, halted=0, all strobes 0 during reset cycle.
REQ-029 reset overrides any state including HALT and mid-OPERAND; no pc strobe issued in the reset cycle.

Structure
REQ-030 Shared package nic8_isa_pkg: state encoding constants, opcode field positions, condition codes, HALT_OP default.
REQ-031 One sub-module jump_condition: inputs cond[1:0], zero_flag, carry_flag; output taken.
REQ-032 Sequencer is a single registered state + IR with combinational output decode.

Verification
REQ-033 Reset, run=1, ROM {8'h01,8'h02} -> pc_inc at cycles 1,3; exec at cycles 2,4; no pc_jump.
REQ-034 ROM {8'h80,8'h10}, run=1 -> FETCH,DECODE,OPERAND; OPERAND: rom_oe=1, pc_jump=1, pc_inc=0; pc becomes 8'h10.
REQ-035 ROM {8'hA0,8'h10} with zero_flag=0 -> pc_inc=1, no pc_jump, pc advances to 2; repeat with zero_flag=1 -> pc_jump=1.
REQ-036 ROM {8'h41,8'h55} -> OPERAND cycle: rom_oe=1, exec=1, pc_inc=1; ir=8'h41.
REQ-037 ROM {8'hFF}: halted=1 from cycle 2; 10 cycles with run=1/step pulses -> no strobes; reset -> state=0, halted=0.
REQ-038 run=0, step pulse 1 cycle -> exactly one instruction executes then idle in FETCH; reset asserted in OPERAND -> next state FETCH, no pc_jump.
